seg7_scan_decoder: RTL and testbench

//  Reverse path of the BCD->7-segment encoder. Snoops a multiplexed multi-digit display bus
//  (segment lines + one-hot digit select) and validates stable patterns. Decodes each pattern

---
 rtl/seg7_pkg.sv | 27 ++
 rtl/seg7_to_bcd.sv | 36 +++
 rtl/seg7_scan_decoder.sv | 160 ++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment constants for the BCD->7seg encoder and the scan decoder.
// Segment bit map (seg[6:0]): [6]=a [5]=b [4]=c [3]=d [2]=e [1]=f [0]=g, active high.
// Encoder and decoder both pull their tables from here so they cannot drift apart.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h7B;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [3:0] BCD_BLANK = 4'hF;

  // Widest digit-select vector the one-hot helper accepts.
  localparam int ONEHOT_MAX_W = 32;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  function automatic logic is_onehot(input logic [ONEHOT_MAX_W-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational 7-segment -> BCD decoder.
// Ports:
//   seg_i   : segment pattern seg[6:0] (dp is not part of the pattern)
//   hit_o   : pattern is one of the digits 0..9
//   blank_o : pattern is all segments off
//   bcd_o   : decoded digit, BCD_BLANK when not a hit
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic       hit_o,
  output logic       blank_o,
  output logic [3:0] bcd_o
);

  always_comb begin
    hit_o = 1'b1;
    bcd_o = BCD_BLANK;
    case (seg_i)
      SEG_0:   bcd_o = 4'd0;
      SEG_1:   bcd_o = 4'd1;
      SEG_2:   bcd_o = 4'd2;
      SEG_3:   bcd_o = 4'd3;
      SEG_4:   bcd_o = 4'd4;
      SEG_5:   bcd_o = 4'd5;
      SEG_6:   bcd_o = 4'd6;
      SEG_7:   bcd_o = 4'd7;
      SEG_8:   bcd_o = 4'd8;
      SEG_9:   bcd_o = 4'd9;
      default: hit_o = 1'b0;
    endcase
  end

  assign blank_o = (seg_i == SEG_BLANK);

endmodule

// File: rtl/seg7_scan_decoder.sv
// Snoops a multiplexed 7-segment display bus, captures patterns that stay stable for
// STABLE_CYCLES samples, decodes them back to BCD into a per-digit image and reports every
// change of the image on a valid/ready update port.
// Ports:
//   clk, rst_n       : clock, async active-low reset
//   seg_in, sel_in   : display bus (segments incl. dp at [7], one-hot digit select)
//   clear            : synchronous clear of image, flags, run state and update port
//   bcd_out          : decoded image, digit i at [4i+3:4i]
//   digit_valid      : digit i holds a decoded 0..9
//   upd_valid/ready  : update event handshake; upd_digit/upd_bcd carry the payload
//   err              : sticky, a non-blank non-digit pattern was captured
//   overrun          : sticky, an event replaced one that was never accepted
// DIGITS must be in 2..32, STABLE_CYCLES in 1..15.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                seg_in,
  input  logic [DIGITS-1:0]         sel_in,
  input  logic                      clear,
  output logic [4*DIGITS-1:0]       bcd_out,
  output logic [DIGITS-1:0]         digit_valid,
  output logic                      upd_valid,
  input  logic                      upd_ready,
  output logic [$clog2(DIGITS)-1:0] upd_digit,
  output logic [3:0]                upd_bcd,
  output logic                      err,
  output logic                      overrun
);

  localparam int DW = $clog2(DIGITS);
  localparam logic [3:0] RUN_MAX = 4'(STABLE_CYCLES);

  logic [DIGITS+7:0]          sample_q;
  logic [3:0]                 run_q, run_d;
  logic                       captured_q, captured_d;
  logic [DIGITS-1:0][3:0]     bcd_q, bcd_d;
  logic [DIGITS-1:0]          dv_q, dv_d;
  logic                       upd_valid_q, upd_valid_d;
  logic [DW-1:0]              upd_digit_q, upd_digit_d;
  logic [3:0]                 upd_bcd_q, upd_bcd_d;
  logic                       err_q, err_d;
  logic                       ovr_q, ovr_d;

  logic [DIGITS-1:0] sel_q;
  logic [6:0]        seg_q;
  logic              hit, blank;
  logic [3:0]        dec_bcd;
  logic [DW-1:0]     idx;
  logic              capture, changed;

  // Decode works off the registered sample, i.e. the pattern that has been stable.
  assign sel_q = sample_q[DIGITS+7:8];
  assign seg_q = sample_q[6:0];

  seg7_to_bcd u_dec (
    .seg_i   (seg_q),
    .hit_o   (hit),
    .blank_o (blank),
    .bcd_o   (dec_bcd)
  );

  always_comb begin
    idx = '0;
    for (int i = 0; i < DIGITS; i++)
      if (sel_q[i]) idx = DW'(i);
  end

  assign capture = (run_q == RUN_MAX) && !captured_q
                 && is_onehot(ONEHOT_MAX_W'(sel_q));
  // Only a capture that alters the stored {valid, nibble} is worth reporting.
  assign changed = capture && ({hit, dec_bcd} != {dv_q[idx], bcd_q[idx]});

  always_comb begin
    run_d       = run_q;
    captured_d  = captured_q;
    bcd_d       = bcd_q;
    dv_d        = dv_q;
    upd_valid_d = upd_valid_q;
    upd_digit_d = upd_digit_q;
    upd_bcd_d   = upd_bcd_q;
    err_d       = err_q;
    ovr_d       = ovr_q;

    if (capture) begin
      captured_d  = 1'b1;
      bcd_d[idx]  = dec_bcd;
      dv_d[idx]   = hit;
      if (!hit && !blank) err_d = 1'b1;
    end

    // A new sample starts a new run, even on the edge that captured the old one.
    if ({sel_in, seg_in} == sample_q) begin
      if (run_q != RUN_MAX) run_d = run_q + 4'd1;
    end else begin
      run_d      = 4'd1;
      captured_d = 1'b0;
    end

    if (changed) begin
      if (upd_valid_q && !upd_ready) ovr_d = 1'b1;
      upd_valid_d = 1'b1;
      upd_digit_d = idx;
      upd_bcd_d   = dec_bcd;
    end else if (upd_valid_q && upd_ready) begin
      upd_valid_d = 1'b0;
    end

    if (clear) begin
      run_d       = '0;
      captured_d  = 1'b0;
      bcd_d       = {DIGITS{BCD_BLANK}};
      dv_d        = '0;
      upd_valid_d = 1'b0;
      upd_digit_d = '0;
      upd_bcd_d   = '0;
      err_d       = 1'b0;
      ovr_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q    <= '0;
      run_q       <= '0;
      captured_q  <= 1'b0;
      bcd_q       <= {DIGITS{BCD_BLANK}};
      dv_q        <= '0;
      upd_valid_q <= 1'b0;
      upd_digit_q <= '0;
      upd_bcd_q   <= '0;
      err_q       <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      sample_q    <= {sel_in, seg_in};
      run_q       <= run_d;
      captured_q  <= captured_d;
      bcd_q       <= bcd_d;
      dv_q        <= dv_d;
      upd_valid_q <= upd_valid_d;
      upd_digit_q <= upd_digit_d;
      upd_bcd_q   <= upd_bcd_d;
      err_q       <= err_d;
      ovr_q       <= ovr_d;
    end
  end

  assign bcd_out     = bcd_q;
  assign digit_valid = dv_q;
  assign upd_valid   = upd_valid_q;
  assign upd_digit   = upd_digit_q;
  assign upd_bcd     = upd_bcd_q;
  assign err         = err_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder (DIGITS=4, STABLE_CYCLES=3): directed scenarios followed by
// random bus traffic, every edge checked against a behavioural model of the decoder.
module tb_seg7_scan_decoder;

  localparam int D = 4;
  localparam int S = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [7:0]     seg_in = '0;
  logic [D-1:0]   sel_in = '0;
  logic           clear = 1'b0;
  logic [4*D-1:0] bcd_out;
  logic [D-1:0]   digit_valid;
  logic           upd_valid;
  logic           upd_ready = 1'b0;
  logic [1:0]     upd_digit;
  logic [3:0]     upd_bcd;
  logic           err;
  logic           overrun;

  int n_vec = 0;
  int n_err = 0;

  seg7_scan_decoder #(.DIGITS(D), .STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .sel_in      (sel_in),
    .clear       (clear),
    .bcd_out     (bcd_out),
    .digit_valid (digit_valid),
    .upd_valid   (upd_valid),
    .upd_ready   (upd_ready),
    .upd_digit   (upd_digit),
    .upd_bcd     (upd_bcd),
    .err         (err),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int   TBL [10] = '{'h7E, 'h30, 'h6D, 'h79, 'h33, 'h5B, 'h5F, 'h70, 'h7F, 'h7B};
  logic [3:0] m_sel;
  logic [7:0] m_seg;
  int   m_run;
  bit   m_capt;
  int   m_bcd [D];
  bit   m_dv [D];
  bit   m_uv, m_err, m_ovr;
  int   m_ud, m_ub;

  task automatic model_clear_outputs();
    for (int i = 0; i < D; i++) begin m_bcd[i] = 15; m_dv[i] = 0; end
    m_uv = 0; m_ud = 0; m_ub = 0; m_err = 0; m_ovr = 0;
  endtask

  task automatic model_reset();
    model_clear_outputs();
    m_sel = '0; m_seg = '0; m_run = 0; m_capt = 0;
  endtask

  // One rising edge with the given inputs present.
  task automatic model_edge(input logic [3:0] sel, input logic [7:0] seg,
                            input bit clr, input bit rdy);
    int idx, val, ones;
    bit cap, hit, blank, chg, same;
    ones = 0; idx = 0;
    for (int i = 0; i < D; i++) if (m_sel[i]) begin ones++; idx = i; end
    cap = (m_run == S) && !m_capt && (ones == 1);
    hit = 0; val = 15;
    for (int d = 0; d < 10; d++) if (int'(m_seg[6:0]) == TBL[d]) begin hit = 1; val = d; end
    blank = (m_seg[6:0] == 7'h00);
    chg = cap && ((hit != m_dv[idx]) || (val != m_bcd[idx]));
    same = ({sel, seg} == {m_sel, m_seg});

    if (cap) begin
      m_capt = 1; m_bcd[idx] = val; m_dv[idx] = hit;
      if (!hit && !blank) m_err = 1;
    end
    if (same) begin
      if (m_run < S) m_run++;
    end else begin
      m_run = 1; m_capt = 0;
    end
    if (chg) begin
      if (m_uv && !rdy) m_ovr = 1;
      m_uv = 1; m_ud = idx; m_ub = val;
    end else if (m_uv && rdy) begin
      m_uv = 0;
    end
    if (clr) begin
      model_clear_outputs();
      m_run = 0; m_capt = 0;
    end
    m_sel = sel; m_seg = seg;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    logic [15:0] eb;
    logic [3:0]  ev;
    for (int i = 0; i < D; i++) begin
      eb[4*i +: 4] = 4'(m_bcd[i]);
      ev[i] = m_dv[i];
    end
    chk("bcd_out",     32'(bcd_out),     32'(eb));
    chk("digit_valid", 32'(digit_valid), 32'(ev));
    chk("upd_valid",   32'(upd_valid),   32'(m_uv));
    chk("upd_digit",   32'(upd_digit),   32'(m_ud));
    chk("upd_bcd",     32'(upd_bcd),     32'(m_ub));
    chk("err",         32'(err),         32'(m_err));
    chk("overrun",     32'(overrun),     32'(m_ovr));
  endtask

  // Called at a negedge; drives, lets one rising edge pass, checks, returns at next negedge.
  task automatic step(input logic [3:0] sel, input logic [7:0] seg,
                      input bit clr, input bit rdy);
    sel_in = sel; seg_in = seg; clear = clr; upd_ready = rdy;
    @(posedge clk);
    model_edge(sel, seg, clr, rdy);
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic hold(input int n, input logic [3:0] sel, input logic [7:0] seg,
                      input bit rdy);
    for (int k = 0; k < n; k++) step(sel, seg, 1'b0, rdy);
  endtask

  initial begin
    logic [3:0] rs;
    logic [7:0] rg;
    int         rh;
    bit         rr;

    // 1: reset
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    chk("rst_bcd", 32'(bcd_out), 32'hFFFF);
    rst_n = 1'b1;

    // 2: digit 1 shows "2"; capture lands on the edge after S stable samples
    hold(S + 1, 4'b0010, 8'h6D, 1'b0);
    chk("t2_bcd1", 32'(bcd_out[7:4]), 32'd2);
    chk("t2_dv",   32'(digit_valid), 32'b0010);
    chk("t2_uv",   32'(upd_valid), 32'd1);
    chk("t2_ud",   32'(upd_digit), 32'd1);
    chk("t2_ub",   32'(upd_bcd), 32'd2);
    hold(10, 4'b0010, 8'h6D, 1'b0);
    chk("t2_noevt_ovr", 32'(overrun), 32'd0);
    step(4'b0010, 8'h6D, 1'b0, 1'b1);   // drain the event

    // 3: too-short run, then zero/multi-hot selects
    hold(2, 4'b0001, 8'h79, 1'b1);
    hold(S + 1, 4'b0001, 8'h30, 1'b1);
    chk("t3_bcd0", 32'(bcd_out[3:0]), 32'd1);
    hold(5, 4'b0011, 8'h5B, 1'b1);
    hold(5, 4'b0000, 8'h5B, 1'b1);
    chk("t3_nocap", 32'(bcd_out[7:0]), 32'h21);

    // 4: dp ignored; then a garbage pattern sets err
    hold(S + 1, 4'b0001, 8'hFF, 1'b1);
    chk("t4_dp8", 32'(bcd_out[3:0]), 32'd8);
    hold(S + 1, 4'b0001, 8'h01, 1'b1);
    chk("t4_inv", 32'(bcd_out[3:0]), 32'hF);
    chk("t4_dv0", 32'(digit_valid[0]), 32'd0);
    chk("t4_err", 32'(err), 32'd1);
    hold(S + 1, 4'b0001, 8'h7E, 1'b1);
    chk("t4_sticky", 32'(err), 32'd1);

    // 5: overrun with the consumer stalled, none with it ready
    step(4'b0000, 8'h00, 1'b1, 1'b1);
    hold(S + 1, 4'b0001, 8'h5B, 1'b0);
    hold(S + 1, 4'b0100, 8'h70, 1'b0);
    chk("t5_ovr", 32'(overrun), 32'd1);
    chk("t5_ud",  32'(upd_digit), 32'd2);
    chk("t5_ub",  32'(upd_bcd), 32'd7);
    step(4'b0000, 8'h00, 1'b1, 1'b1);
    hold(S + 1, 4'b0001, 8'h5B, 1'b1);
    hold(S + 1, 4'b0100, 8'h70, 1'b1);
    chk("t5_noovr", 32'(overrun), 32'd0);
    chk("t5_ub2",   32'(upd_bcd), 32'd7);

    // 6a: reset after 2 of 3 stable samples
    hold(2, 4'b1000, 8'h33, 1'b1);
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    chk("t6_rst_bcd", 32'(bcd_out), 32'hFFFF);
    hold(S + 1, 4'b1000, 8'h33, 1'b1);
    chk("t6_after_rst", 32'(bcd_out[15:12]), 32'd4);

    // 6b: clear on the edge a capture is due
    step(4'b0000, 8'h00, 1'b1, 1'b1);
    hold(S, 4'b0100, 8'h7B, 1'b0);
    step(4'b0100, 8'h7B, 1'b1, 1'b0);
    chk("t6_clr_bcd", 32'(bcd_out), 32'hFFFF);
    chk("t6_clr_uv",  32'(upd_valid), 32'd0);
    chk("t6_clr_dv",  32'(digit_valid), 32'd0);

    // random traffic
    for (int r = 0; r < 80; r++) begin
      case ($urandom_range(0, 9))
        7:       rs = 4'b0000;
        8, 9:    rs = 4'($urandom);
        default: rs = 4'(1 << $urandom_range(0, 3));
      endcase
      case ($urandom_range(0, 9))
        0:       rg = 8'($urandom_range(0, 1) << 7);
        1:       rg = 8'($urandom);
        default: rg = {1'($urandom_range(0, 1)), 7'(TBL[$urandom_range(0, 9)])};
      endcase
      rh = $urandom_range(1, 6);
      for (int k = 0; k < rh; k++) begin
        rr = 1'($urandom_range(0, 1));
        step(rs, rg, ($urandom_range(0, 60) == 0), rr);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
